// File: rtl/instr_enc_pkg.sv
// instr_enc_pkg: opcode, exe_cmd and branch encodings plus field widths shared by encoder and decoder.
package instr_enc_pkg;
  localparam int OP_W    = 6;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 16;
  localparam int EXE_W   = 4;
  localparam int INSTR_W = 32;
  localparam logic [EXE_W-1:0] EXE_ADD = 4'b0000;
  localparam logic [EXE_W-1:0] EXE_SUB = 4'b0010;
  localparam logic [EXE_W-1:0] EXE_AND = 4'b0100;
  localparam logic [EXE_W-1:0] EXE_OR  = 4'b0101;
  localparam logic [EXE_W-1:0] EXE_NOR = 4'b0110;
  localparam logic [EXE_W-1:0] EXE_XOR = 4'b0111;
  localparam logic [EXE_W-1:0] EXE_SLL = 4'b1000;
  localparam logic [EXE_W-1:0] EXE_SRA = 4'b1001;
  localparam logic [EXE_W-1:0] EXE_SRL = 4'b1010;
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;
  localparam logic [OP_W-1:0] OP_NOP  = 6'd0;
  localparam logic [OP_W-1:0] OP_ADD  = 6'd1;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd3;
  localparam logic [OP_W-1:0] OP_AND  = 6'd5;
  localparam logic [OP_W-1:0] OP_OR   = 6'd6;
  localparam logic [OP_W-1:0] OP_NOR  = 6'd7;
  localparam logic [OP_W-1:0] OP_XOR  = 6'd8;
  localparam logic [OP_W-1:0] OP_SLA  = 6'd9;
  localparam logic [OP_W-1:0] OP_SLL  = 6'd10;
  localparam logic [OP_W-1:0] OP_SRA  = 6'd11;
  localparam logic [OP_W-1:0] OP_SRL  = 6'd12;
  localparam logic [OP_W-1:0] OP_ADDI = 6'd32;
  localparam logic [OP_W-1:0] OP_SUBI = 6'd33;
  localparam logic [OP_W-1:0] OP_LD   = 6'd36;
  localparam logic [OP_W-1:0] OP_ST   = 6'd37;
  localparam logic [OP_W-1:0] OP_BEZ  = 6'd40;
  localparam logic [OP_W-1:0] OP_BNE  = 6'd41;
  localparam logic [OP_W-1:0] OP_JMP  = 6'd42;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} fifo_state_e;
endpackage

// File: rtl/instr_enc_fifo.sv
// instr_enc_fifo: 2-entry output buffer holding {instruction, address}; head is registered and
// drives the outputs directly, ready is a pure function of the registered state.
module instr_enc_fifo
  import instr_enc_pkg::*;
#(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic         ready_o,
  output logic [W-1:0] data_o
);
  fifo_state_e state_q;
  logic [W-1:0] head_q, tail_q;
  logic push, pop;
  assign push    = push_i && state_q != FULL;
  assign pop     = pop_i && state_q != EMPTY;
  assign valid_o = state_q != EMPTY;
  assign ready_o = state_q != FULL;
  assign data_o  = head_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          head_q  <= data_i;
          state_q <= ONE;
        end
        ONE: if (push && pop) head_q <= data_i;
          else if (push) begin
            tail_q  <= data_i;
            state_q <= FULL;
          end else if (pop) state_q <= EMPTY;
        FULL: if (pop) begin
          head_q  <= tail_q;
          state_q <= ONE;
        end
        default: state_q <= EMPTY;
      endcase
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: maps a decoded control bundle to a 32-bit instruction word with its memory address.
// Optional INSTR_ENC_ERRCNT_EN adds a saturating err_count output.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EXE_W-1:0]  exe_cmd,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              wb_en,
  input  logic              is_immediate,
  input  logic [1:0]        branch_type,
  input  logic [REG_W-1:0]  dest,
  input  logic [REG_W-1:0]  src1,
  input  logic [REG_W-1:0]  src2,
  input  logic [IMM_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_addr,
`ifdef INSTR_ENC_ERRCNT_EN
  output logic [15:0]       err_count,
`endif
  output logic              err
);
  logic [5:0] ctl;
  logic [OP_W-1:0] op;
  logic legal, rfmt, accept, push, err_q;
  logic [INSTR_W-1:0] word;
  logic [ADDR_W-1:0] addr_q, addr_d;
  assign ctl = {wb_en, is_immediate, mem_read, mem_write, branch_type};
  always_comb begin
    op    = OP_NOP;
    legal = 1'b1;
    rfmt  = 1'b0;
    if (ctl == {4'b1000, BR_NONE}) begin
      rfmt = 1'b1;
      case (exe_cmd)
        EXE_ADD: op = OP_ADD;
        EXE_SUB: op = OP_SUB;
        EXE_AND: op = OP_AND;
        EXE_OR:  op = OP_OR;
        EXE_NOR: op = OP_NOR;
        EXE_XOR: op = OP_XOR;
        EXE_SLL: op = OP_SLL;
        EXE_SRA: op = OP_SRA;
        EXE_SRL: op = OP_SRL;
        default: legal = 1'b0;
      endcase
    end else begin
      case ({exe_cmd, ctl})
        {EXE_ADD, 4'b0000, BR_NONE}: op = OP_NOP;
        {EXE_ADD, 4'b1100, BR_NONE}: op = OP_ADDI;
        {EXE_SUB, 4'b1100, BR_NONE}: op = OP_SUBI;
        {EXE_ADD, 4'b1110, BR_NONE}: op = OP_LD;
        {EXE_ADD, 4'b1101, BR_NONE}: op = OP_ST;
        {EXE_ADD, 4'b0100, BR_BEZ}:  op = OP_BEZ;
        {EXE_ADD, 4'b0100, BR_BNE}:  op = OP_BNE;
        {EXE_ADD, 4'b0100, BR_JMP}:  op = OP_JMP;
        default: legal = 1'b0;
      endcase
    end
  end
  assign word   = op == OP_NOP ? '0 : rfmt ? {op, dest, src1, src2, 11'b0} : {op, dest, src1, imm};
  assign accept = in_valid && in_ready;
  assign push   = accept && legal;
  assign addr_d = push ? addr_q + 1'b1 : addr_q;
  assign err    = err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= accept && !legal;
    end
  end
`ifdef INSTR_ENC_ERRCNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) err_cnt_q <= '0;
    else if (accept && !legal && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
  end
  assign err_count = err_cnt_q;
`endif
  instr_enc_fifo #(.W(INSTR_W + ADDR_W)) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .data_i ({word, addr_q}),
    .pop_i  (out_ready),
    .valid_o(out_valid),
    .ready_o(in_ready),
    .data_o ({out_instr, out_addr})
  );
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed literal checks plus randomized bundles against a queue-based reference model.
module tb_instr_encoder;
  localparam int AW = 2;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, mem_read, mem_write, wb_en, is_immediate, out_valid, out_ready, err;
  logic [3:0] exe_cmd;
  logic [1:0] branch_type;
  logic [4:0] dest, src1, src2;
  logic [15:0] imm;
  logic [31:0] out_instr;
  logic [AW-1:0] out_addr;
`ifdef INSTR_ENC_ERRCNT_EN
  logic [15:0] err_count;
`endif
  int checks = 0, errors = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .exe_cmd(exe_cmd),
    .mem_read(mem_read), .mem_write(mem_write), .wb_en(wb_en), .is_immediate(is_immediate),
    .branch_type(branch_type), .dest(dest), .src1(src1), .src2(src2), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
`ifdef INSTR_ENC_ERRCNT_EN
    .err_count(err_count),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  // Legal bundles: exe_cmd, control {wb_en,is_immediate,mem_read,mem_write,branch_type}, opcode, R-format
  typedef struct {logic [3:0] exe; logic [5:0] ctl; logic [5:0] op; bit rf;} ent_t;
  ent_t tbl[$];
  logic [31:0] qi[$];
  logic [AW-1:0] qa[$];
  logic [AW-1:0] m_addr;
  bit m_err;
  int m_cnt;

  function automatic void add(input logic [3:0] e, input logic [5:0] c, input int o, input bit rf);
    ent_t x;
    x.exe = e; x.ctl = c; x.op = 6'(o); x.rf = rf;
    tbl.push_back(x);
  endfunction

  function automatic int find(input logic [3:0] e, input logic [5:0] c);
    foreach (tbl[k]) if (tbl[k].exe == e && tbl[k].ctl == c) return k;
    return -1;
  endfunction

  function automatic logic [31:0] enc(input int k);
    if (tbl[k].op == 6'd0) return 32'h0;
    return tbl[k].rf ? {tbl[k].op, dest, src1, src2, 11'b0} : {tbl[k].op, dest, src1, imm};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    int k;
    bit rdy;
    if (!rst_n) begin
      qi.delete(); qa.delete(); m_addr = '0; m_err = 0; m_cnt = 0;
    end else begin
      rdy = qi.size() < 2;
      m_err = 0;
      if (out_ready && qi.size() > 0) begin
        void'(qi.pop_front()); void'(qa.pop_front());
      end
      if (in_valid && rdy) begin
        k = find(exe_cmd, {wb_en, is_immediate, mem_read, mem_write, branch_type});
        if (k < 0) begin
          m_err = 1;
          if (m_cnt < 65535) m_cnt++;
        end else begin
          qi.push_back(enc(k)); qa.push_back(m_addr); m_addr = m_addr + 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("in_ready", {31'b0, in_ready}, {31'b0, qi.size() < 2});
    chk("out_valid", {31'b0, out_valid}, {31'b0, qi.size() > 0});
    chk("err", {31'b0, err}, {31'b0, m_err});
    if (qi.size() > 0) begin
      chk("out_instr", out_instr, qi[0]);
      chk("out_addr", 32'(out_addr), 32'(qa[0]));
    end
`ifdef INSTR_ENC_ERRCNT_EN
    chk("err_count", 32'(err_count), 32'(m_cnt));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_ctl(input int k);
    exe_cmd = tbl[k].exe;
    {wb_en, is_immediate, mem_read, mem_write, branch_type} = tbl[k].ctl;
  endtask

  task automatic set_f(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2, input logic [15:0] im);
    dest = d; src1 = s1; src2 = s2; imm = im;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_a[5];
    int r;
    add(4'b0000, 6'b000000, 0, 0);
    add(4'b0000, 6'b100000, 1, 1);  add(4'b0010, 6'b100000, 3, 1);
    add(4'b0100, 6'b100000, 5, 1);  add(4'b0101, 6'b100000, 6, 1);
    add(4'b0110, 6'b100000, 7, 1);  add(4'b0111, 6'b100000, 8, 1);
    add(4'b1000, 6'b100000, 10, 1); add(4'b1001, 6'b100000, 11, 1);
    add(4'b1010, 6'b100000, 12, 1);
    add(4'b0000, 6'b110000, 32, 0); add(4'b0010, 6'b110000, 33, 0);
    add(4'b0000, 6'b111000, 36, 0); add(4'b0000, 6'b110100, 37, 0);
    add(4'b0000, 6'b010001, 40, 0); add(4'b0000, 6'b010010, 41, 0);
    add(4'b0000, 6'b010011, 42, 0);
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; set_ctl(0); set_f(0, 0, 0, 0);
    tick(); tick();
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    rst_n = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
    set_ctl(1); set_f(3, 1, 2, 16'h0);
    tick();
    chk("add_word", out_instr, 32'h04611000);
    chk("add_addr", 32'(out_addr), 32'h0);
    set_ctl(12); set_f(4, 0, 0, 16'h0010);
    tick();
    chk("ld_word", out_instr, 32'h90800010);
    chk("ld_addr", 32'(out_addr), 32'h1);
    exe_cmd = 4'b0000; {wb_en, is_immediate, mem_read, mem_write, branch_type} = 6'b111100;
    tick();
    chk("illegal_err", {31'b0, err}, 32'h1);
    chk("illegal_no_valid", {31'b0, out_valid}, 32'h0);
    set_ctl(1); set_f(7, 2, 3, 16'h0);
    tick();
    chk("after_illegal_addr", 32'(out_addr), 32'h2);
    chk("err_one_cycle", {31'b0, err}, 32'h0);
    in_valid = 1'b0;
    tick();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; set_ctl(2); set_f(1, 1, 1, 0);
    tick();
    set_f(2, 2, 2, 0);
    tick();
    chk("full_in_ready", {31'b0, in_ready}, 32'h0);
    set_f(3, 3, 3, 0);
    tick();
    chk("full_hold_addr", 32'(out_addr), 32'h0);
    out_ready = 1'b1;
    tick();
    chk("drain_addr1", 32'(out_addr), 32'h1);
    tick();
    chk("drain_addr2", 32'(out_addr), 32'h2);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0; in_valid = 1'b1; set_ctl(5);
    tick(); tick();
    do_reset();
    chk("rst_full_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_full_ready", {31'b0, in_ready}, 32'h1);
`ifdef INSTR_ENC_ERRCNT_EN
    chk("rst_err_count", 32'(err_count), 32'h0);
`endif
    exp_a = '{0, 1, 2, 3, 0};
    out_ready = 1'b1; in_valid = 1'b1; set_ctl(1);
    for (int i = 0; i < 5; i++) begin
      set_f(5'(i), 5'(i + 1), 5'(i + 2), 0);
      tick();
      chk("wrap_addr", 32'(out_addr), 32'(exp_a[i]));
    end
    for (int i = 0; i < 3000; i++) begin
      rst_n = $urandom_range(0, 299) != 0;
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 6;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        r = $urandom_range(0, tbl.size() - 1);
        set_ctl(r);
        set_f(5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
        if (r == 0) set_f(0, 0, 0, 0);
      end else begin
        exe_cmd = 4'($urandom);
        {wb_en, is_immediate, mem_read, mem_write, branch_type} = 6'($urandom);
        set_f(5'($urandom), 5'($urandom), 5'($urandom), 16'($urandom));
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
